// File: rtl/alarm_pkg.sv
// Shared types for the alarm scheduler: packed BCD time,
// controller state encoding and the midnight constant.
package alarm_pkg;

  typedef struct packed {
    logic [3:0] hour_t;
    logic [3:0] hour_o;
    logic [3:0] min_t;
    logic [3:0] min_o;
  } bcd_time_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  localparam logic [15:0] TIME_MIDNIGHT = 16'h0000;

endpackage

// File: rtl/alarm_scheduler_bcd_time_add.sv
// Combinational BCD time-of-day plus 0..9 minutes,
// minutes carry into hours, hours wrap at 24.
module bcd_time_add
  import alarm_pkg::*;
(
  input  logic [15:0] t_i,
  input  logic [3:0]  m_i,
  output logic [15:0] sum_o
);

  bcd_time_t  t;
  bcd_time_t  s;
  logic [4:0] mo;
  logic [3:0] md;
  logic [3:0] ho;
  logic [3:0] hd;
  logic       cm;
  logic       ch;

  always_comb begin
    t  = bcd_time_t'(t_i);
    mo = 5'(t.min_o) + 5'(m_i);
    cm = (mo > 5'd9);
    s.min_o = cm ? 4'(mo - 5'd10) : mo[3:0];
    md = t.min_t + 4'(cm);
    ch = (md == 4'd6);
    s.min_t = ch ? 4'd0 : md;
    ho = t.hour_o + 4'(ch);
    hd = t.hour_t;
    // 24:00 folds back to 00:00
    if (hd == 4'd2 && ho == 4'd4) begin
      hd = 4'd0;
      ho = 4'd0;
    end else if (ho == 4'd10) begin
      ho = 4'd0;
      hd = hd + 4'd1;
    end
    s.hour_t = hd;
    s.hour_o = ho;
    sum_o = s;
  end

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm controller: per-minute slot match, single
// sound owner, ring/snooze/dismiss sequencing on the 1 Hz tick.
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int unsigned N_SLOTS    = 4,
  parameter int unsigned RING_SEC   = 30,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3,
  localparam int SW = $clog2(N_SLOTS)
) (
  input  logic               clk_sec,
  input  logic               rstn,
  input  logic [15:0]        now_time,
  input  logic               wr_en,
  input  logic [SW-1:0]      wr_slot,
  input  logic [15:0]        wr_time,
  input  logic               wr_enable,
  input  logic               btn_stop,
  input  logic               btn_snooze,
  output logic               aud_en,
  output logic               ringing,
  output logic               snoozed,
  output logic [SW-1:0]      active_slot,
  output logic [N_SLOTS-1:0] missed
);

  logic [15:0]        time_q [N_SLOTS];
  logic [N_SLOTS-1:0] en_q;
  logic [15:0]        prev_q;
  state_t             state_q, state_d;
  logic [SW-1:0]      act_q, act_d;
  logic [7:0]         rcnt_q, rcnt_d;
  logic [3:0]         scnt_q, scnt_d;
  logic [15:0]        tgt_q, tgt_d;
  logic [N_SLOTS-1:0] miss_q, miss_d;

  logic               new_min;
  logic [N_SLOTS-1:0] match;
  logic [N_SLOTS-1:0] grant_oh;
  logic [N_SLOTS-1:0] set_miss;
  logic [SW-1:0]      grant;
  logic               any_match;
  logic               dis_act;
  logic               tgt_hit;
  logic [15:0]        snz_sum;

  bcd_time_add u_add (
    .t_i   (now_time),
    .m_i   (4'(SNOOZE_MIN)),
    .sum_o (snz_sum)
  );

  assign new_min   = (now_time != prev_q);
  assign any_match = |match;
  assign tgt_hit   = new_min && (now_time == tgt_q);
  assign dis_act   = wr_en && !wr_enable &&
                     (wr_slot == act_q);

  always_comb begin
    for (int i = 0; i < N_SLOTS; i++)
      match[i] = en_q[i] && new_min &&
                 (time_q[i] == now_time);
  end

  always_comb begin
    grant    = '0;
    grant_oh = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (match[i]) begin
        grant       = SW'(i);
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sec or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_SLOTS; i++)
        time_q[i] <= TIME_MIDNIGHT;
      en_q <= '0;
    end else if (wr_en) begin
      time_q[wr_slot] <= wr_time;
      en_q[wr_slot]   <= wr_enable;
    end
  end

  always_ff @(posedge clk_sec or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      act_q   <= '0;
      rcnt_q  <= '0;
      scnt_q  <= '0;
      tgt_q   <= TIME_MIDNIGHT;
      miss_q  <= '0;
      prev_q  <= TIME_MIDNIGHT;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      rcnt_q  <= rcnt_d;
      scnt_q  <= scnt_d;
      tgt_q   <= tgt_d;
      miss_q  <= miss_d;
      prev_q  <= now_time;
    end
  end

  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    rcnt_d   = rcnt_q;
    scnt_d   = scnt_q;
    tgt_d    = tgt_q;
    set_miss = '0;
    unique case (state_q)
      IDLE: begin
        if (any_match) begin
          state_d  = RING;
          act_d    = grant;
          rcnt_d   = '0;
          scnt_d   = '0;
          set_miss = match & ~grant_oh;
        end
      end
      RING: begin
        rcnt_d   = rcnt_q + 8'd1;
        set_miss = match;
        if (dis_act || btn_stop) begin
          state_d = IDLE;
        end else if (btn_snooze &&
                     scnt_q < 4'(MAX_SNOOZE)) begin
          state_d = SNOOZE;
          tgt_d   = snz_sum;
          scnt_d  = scnt_q + 4'd1;
        end else if (rcnt_q == 8'(RING_SEC - 1)) begin
          state_d = IDLE;
          set_miss[act_q] = 1'b1;
        end
      end
      SNOOZE: begin
        if (dis_act || btn_stop) begin
          state_d  = IDLE;
          set_miss = match;
        end else if (any_match) begin
          state_d  = RING;
          act_d    = grant;
          rcnt_d   = '0;
          scnt_d   = '0;
          set_miss = match & ~grant_oh;
        end else if (tgt_hit) begin
          state_d = RING;
          rcnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // a slot write clears its sticky bit even if set now
    miss_d = miss_q | set_miss;
    if (wr_en)
      miss_d[wr_slot] = 1'b0;
  end

  always_comb begin
    aud_en      = (state_q == RING);
    ringing     = (state_q == RING);
    snoozed     = (state_q == SNOOZE);
    active_slot = act_q;
    missed      = miss_q;
  end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler with hand-computed
// expectations routed through a single check task.
module tb_alarm_scheduler;

  logic        clk_sec = 1'b0;
  logic        rstn;
  logic [15:0] now_time;
  logic        wr_en;
  logic [1:0]  wr_slot;
  logic [15:0] wr_time;
  logic        wr_enable;
  logic        btn_stop;
  logic        btn_snooze;
  logic        aud_en;
  logic        ringing;
  logic        snoozed;
  logic [1:0]  active_slot;
  logic [3:0]  missed;

  int n_tests = 0;
  int n_fail  = 0;

  alarm_scheduler dut (
    .clk_sec     (clk_sec),
    .rstn        (rstn),
    .now_time    (now_time),
    .wr_en       (wr_en),
    .wr_slot     (wr_slot),
    .wr_time     (wr_time),
    .wr_enable   (wr_enable),
    .btn_stop    (btn_stop),
    .btn_snooze  (btn_snooze),
    .aud_en      (aud_en),
    .ringing     (ringing),
    .snoozed     (snoozed),
    .active_slot (active_slot),
    .missed      (missed)
  );

  always #5 clk_sec = ~clk_sec;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sec);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] s,
                    input logic [15:0] t,
                    input logic e);
    wr_en     = 1'b1;
    wr_slot   = s;
    wr_time   = t;
    wr_enable = e;
    tick();
    wr_en     = 1'b0;
  endtask

  task automatic set_now(input logic [15:0] t);
    now_time = t;
    tick();
  endtask

  task automatic press_snooze();
    btn_snooze = 1'b1;
    tick();
    btn_snooze = 1'b0;
  endtask

  task automatic press_stop();
    btn_stop = 1'b1;
    tick();
    btn_stop = 1'b0;
  endtask

  initial begin
    rstn       = 1'b0;
    now_time   = 16'h0000;
    wr_en      = 1'b0;
    wr_slot    = 2'd0;
    wr_time    = 16'h0000;
    wr_enable  = 1'b0;
    btn_stop   = 1'b0;
    btn_snooze = 1'b0;
    ticks(2);
    check("rst_aud", 32'(aud_en), 32'd0);
    check("rst_ring", 32'(ringing), 32'd0);
    check("rst_snz", 32'(snoozed), 32'd0);
    check("rst_act", 32'(active_slot), 32'd0);
    check("rst_miss", 32'(missed), 32'd0);
    rstn = 1'b1;
    tick();
    check("rel_0000_idle", 32'(ringing), 32'd0);

    // basic trigger and auto-dismiss after 30 s
    wr(2'd0, 16'h0730, 1'b1);
    set_now(16'h0729);
    check("pre_match", 32'(aud_en), 32'd0);
    set_now(16'h0730);
    check("trig_aud", 32'(aud_en), 32'd1);
    check("trig_act", 32'(active_slot), 32'd0);
    ticks(29);
    check("ring29_aud", 32'(aud_en), 32'd1);
    tick();
    check("timeout_aud", 32'(aud_en), 32'd0);
    check("timeout_miss", 32'(missed), 32'h1);

    // snooze chain, limit of three
    wr(2'd0, 16'h0730, 1'b1);
    check("wr_clr_miss", 32'(missed), 32'h0);
    set_now(16'h0729);
    set_now(16'h0730);
    check("snz_ring0", 32'(ringing), 32'd1);
    press_snooze();
    check("snz1_snz", 32'(snoozed), 32'd1);
    check("snz1_aud", 32'(aud_en), 32'd0);
    set_now(16'h0734);
    check("snz1_wait", 32'(snoozed), 32'd1);
    set_now(16'h0735);
    check("snz1_rering", 32'(ringing), 32'd1);
    press_snooze();
    set_now(16'h0740);
    check("snz2_rering", 32'(ringing), 32'd1);
    press_snooze();
    check("snz3_snz", 32'(snoozed), 32'd1);
    set_now(16'h0745);
    check("snz3_rering", 32'(ringing), 32'd1);
    press_snooze();
    check("snz4_ign_ring", 32'(ringing), 32'd1);
    check("snz4_ign_snz", 32'(snoozed), 32'd0);
    ticks(3);
    check("snz4_still", 32'(aud_en), 32'd1);
    press_stop();
    check("stop_aud", 32'(aud_en), 32'd0);
    check("stop_miss", 32'(missed), 32'h0);

    // arbitration between two simultaneous slots
    wr(2'd1, 16'h0600, 1'b1);
    wr(2'd2, 16'h0600, 1'b1);
    set_now(16'h0559);
    set_now(16'h0600);
    check("arb_act", 32'(active_slot), 32'd1);
    check("arb_miss", 32'(missed), 32'h4);
    press_stop();
    wr(2'd2, 16'h0600, 1'b1);
    check("arb_clr", 32'(missed), 32'h0);

    // snooze across midnight
    wr(2'd3, 16'h2358, 1'b1);
    set_now(16'h2357);
    set_now(16'h2358);
    check("mid_act", 32'(active_slot), 32'd3);
    press_snooze();
    check("mid_snz", 32'(snoozed), 32'd1);
    set_now(16'h0002);
    check("mid_wait", 32'(snoozed), 32'd1);
    set_now(16'h0003);
    check("mid_rering", 32'(ringing), 32'd1);
    check("mid_act2", 32'(active_slot), 32'd3);

    // stop wins over snooze
    btn_stop   = 1'b1;
    btn_snooze = 1'b1;
    tick();
    btn_stop   = 1'b0;
    btn_snooze = 1'b0;
    check("both_ring", 32'(ringing), 32'd0);
    check("both_snz", 32'(snoozed), 32'd0);

    // disabling the active slot while snoozed
    set_now(16'h2357);
    set_now(16'h2358);
    check("dis_ring", 32'(ringing), 32'd1);
    press_snooze();
    check("dis_snz", 32'(snoozed), 32'd1);
    wr(2'd3, 16'h2358, 1'b0);
    check("dis_idle", 32'(snoozed), 32'd0);
    check("dis_ring2", 32'(ringing), 32'd0);
    check("dis_miss", 32'(missed), 32'h0);

    // asynchronous reset mid-ring
    set_now(16'h0729);
    set_now(16'h0730);
    check("ar_ring", 32'(aud_en), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("ar_aud", 32'(aud_en), 32'd0);
    check("ar_ring0", 32'(ringing), 32'd0);
    tick();
    rstn = 1'b1;
    wr(2'd0, 16'h0730, 1'b1);
    ticks(3);
    check("ar_noretrig", 32'(aud_en), 32'd0);
    set_now(16'h0729);
    check("ar_0729", 32'(aud_en), 32'd0);
    set_now(16'h0730);
    check("ar_retrig", 32'(aud_en), 32'd1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_scheduler.md
Name: alarm_scheduler

Overview:
Multi-slot alarm controller for the clock/alarm design. It stores N_SLOTS alarm times in packed BCD and compares them against the running time once per minute. It grants the single sound resource to one slot at a time and sequences ringing, snooze and dismissal. It drives aud_en directly to the audio path and runs from the 1 Hz second tick.

Parameters:
N_SLOTS, 4, number of alarm slots (2..8); slot index width SW = $clog2(N_SLOTS)
RING_SEC, 30, seconds an alarm rings before auto-dismiss (1..255)
SNOOZE_MIN, 5, snooze delay in minutes (1..9)
MAX_SNOOZE, 3, snoozes allowed per alarm event before snooze is ignored

Ports:
clk_sec  in  1  1 Hz clock, single clock domain; all logic on posedge
rstn  in  1  asynchronous, active-low reset
now_time  in  16  current time, packed BCD {hourdec,hourone,mindec,minone}
wr_en  in  1  write slot configuration this cycle
wr_slot  in  SW  slot to write
wr_time  in  16  alarm time, packed BCD
wr_enable  in  1  slot enable bit written together with wr_time
btn_stop  in  1  dismiss pulse, synchronous to clk_sec (debounced upstream)
btn_snooze  in  1  snooze pulse, synchronous to clk_sec
aud_en  out  1  sound enable
ringing  out  1  high in RING
snoozed  out  1  high in SNOOZE
active_slot  out  SW  slot that owns the sound resource (valid when ringing|snoozed)
missed  out  N_SLOTS  sticky per slot: alarm auto-dismissed or lost arbitration; cleared by writing that slot

Behaviour:
- Reset: all slot times 16'h0000, all enables 0, state IDLE; aud_en, ringing, snoozed, active_slot, missed all 0; prev_time=0; counters 0.
- new_min = (now_time != prev_time); prev_time <= now_time every cycle. Triggers are evaluated only when new_min=1, so each slot fires at most once per minute. If now_time is 00:00 at reset release, no trigger occurs at 00:00.
- match[i] = en[i] & (time[i] == now_time) & new_min. Grant goes to the lowest-index match. Other matching slots set their missed bit in the same cycle.
- Writes update registers the next cycle. A write to slot k clears missed[k]. If both happen in one cycle, the write wins over a set of missed[k].
- States:
  - IDLE: on any match -> RING. active_slot=grant, ring_cnt=0, snooze_cnt=0, snooze_target unchanged.
  - RING: aud_en=1, ringing=1. ring_cnt increments each cycle.
    - btn_stop -> IDLE.
    - btn_snooze with snooze_cnt<MAX_SNOOZE -> SNOOZE; snooze_target=now_time+SNOOZE_MIN; snooze_cnt++.
    - btn_snooze with snooze_cnt==MAX_SNOOZE is ignored.
    - ring_cnt==RING_SEC-1 -> IDLE and set missed[active_slot].
    - stop and snooze in the same cycle: stop wins.
  - SNOOZE: aud_en=0, snoozed=1.
    - now_time==snooze_target & new_min -> RING, ring_cnt=0.
    - btn_stop -> IDLE.
    - Any other slot match -> RING on the new grant; snooze is cancelled and snooze_cnt=0.
    - A match of active_slot itself re-enters RING the same way.
- Slot disabled via write (wr_enable=0 to active_slot) while in RING or SNOOZE -> IDLE the next cycle, with no missed bit set.
- Matches arriving in RING are not granted; they set their missed bit.
- Outputs are registered: state change and aud_en take effect on the edge after the triggering input. Latency from now_time match to aud_en=1 is one clk_sec cycle.
- Snooze arithmetic is BCD time addition with carry and wrap at 24 h: minutes mod 60 carry into hours, hours mod 24. Example: 23:58+5 -> 00:03.
- Non-BCD time input digits: the comparison is purely bitwise. Behaviour of the adder on illegal BCD is undefined; the bench does not drive it.
- Asynchronous reset mid-RING drops aud_en immediately and returns all state to reset values.

Decomposition:
- Package alarm_pkg:
  - typedef bcd_time_t (packed struct of four 4-bit digits)
  - enum state_t {IDLE, RING, SNOOZE}
  - constant TIME_MIDNIGHT
- Sub-module bcd_time_add: purely combinational BCD time + minutes (0..9) with 24 h wrap, instanced once for snooze_target.

Test Plan:
- Slot0=07:30 enabled; now_time steps 07:29->07:30 -> aud_en=1 next cycle, active_slot=0. Hold RING_SEC=30 cycles with no buttons -> IDLE, missed[0]=1.
- Ringing slot0, btn_snooze at 07:30 -> snoozed=1, aud_en=0. now_time 07:35 -> ringing again. After a 3rd snooze, a 4th btn_snooze is ignored and the alarm rings until btn_stop.
- Slots 1 and 2 both 06:00 enabled -> active_slot=1, missed[2]=1. Writing slot2 clears missed[2].
- Snooze issued at 23:58 -> snooze_target 00:03; RING re-entered at 00:03.
- btn_stop and btn_snooze in the same RING cycle -> IDLE, snoozed=0. Separately, disabling the active slot while in SNOOZE -> IDLE with missed unchanged.
- rstn asserted while RING -> aud_en=0 asynchronously. After release with now_time held at the alarm minute -> no re-trigger until the next matching minute edge.
